// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the RAM access arbiter.
//   state_e            : arbiter FSM states
//   CMD_*              : 2-bit opcodes placed in the top bits of a RAM command
//   DEFAULT_ADDR_SIZE  : default RAM address / data width
//   issues_cmd()       : true for states that drive a command word to the RAM
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DEFAULT_ADDR_SIZE = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_CMD  = 3'd4,
    RD_WAIT = 3'd5
  } state_e;

  // Each command-issuing state lasts one cycle and owns the RAM strobe.
  function automatic logic issues_cmd(input state_e s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) || (s == RD_CMD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: combinational one-hot winner, registered pointer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req        : request vector (NUM_REQ bits)
//   advance    : move the pointer to the current winner this cycle
//   grant      : one-hot winner (all zero when no request)
//   grant_idx  : binary index of the winner
//   grant_any  : at least one request present
// After reset the pointer sits at NUM_REQ-1, so requester 0 is searched first.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cand;

  // Pointer holds the last winner; it only moves when a grant is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_W'(NUM_REQ - 1);
    end else if (advance && grant_any) begin
      ptr_q <= grant_idx;
    end
  end

  // Search starts one past the pointer and wraps, so the last winner has
  // lowest priority on the next round.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
// Shares the single-port RAM command interface between NUM_REQ requesters.
// Whole write/read transactions are serialised into RAM command words:
//   write : {00,addr} then {01,data}
//   read  : {10,addr} then {11,0}, then wait for ram_tx_valid (with timeout)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid/ready : per-requester handshake, ready is one-hot, IDLE only
//   req_write       : 1 = write, 0 = read
//   req_addr/wdata  : packed per requester, [i*ADDR_SIZE +: ADDR_SIZE]
//   rsp_valid       : one-cycle one-hot completion pulse to the owner
//   rsp_rdata       : read data (0 for writes and timeouts)
//   rsp_err         : read timed out
//   busy            : FSM not in IDLE
//   ram_din         : registered command word, zero whenever no strobe
//   ram_rx_valid    : registered command strobe
//   ram_dout        : RAM read data
//   ram_tx_valid    : RAM read data valid (only honoured in RD_WAIT)
// ---------------------------------------------------------------------------
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_SIZE  = DEFAULT_ADDR_SIZE,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [ADDR_SIZE-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [ADDR_SIZE+1:0]           ram_din,
  output logic                           ram_rx_valid,
  input  logic [ADDR_SIZE-1:0]           ram_dout,
  input  logic                           ram_tx_valid
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_e state_q, state_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 grant_fire;

  logic [PTR_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [CNT_W-1:0]     tmo_cnt_q;
  logic                 rd_timeout_hit;
  logic [ADDR_SIZE+1:0] ram_din_d;

  logic [ADDR_SIZE-1:0] addr_arr  [NUM_REQ];
  logic [ADDR_SIZE-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_arr[g] = req_wdata[g*ADDR_SIZE +: ADDR_SIZE];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (grant_fire),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Read gives up on the last allowed RD_WAIT cycle that still has no data.
  assign rd_timeout_hit = (state_q == RD_WAIT) && !ram_tx_valid &&
                          (tmo_cnt_q == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every command state is a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          state_d = req_write[arb_idx] ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: state_d = IDLE;
      RD_ADDR: state_d = RD_CMD;
      RD_CMD:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (ram_tx_valid || rd_timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs; requests are only accepted in IDLE.
  always_comb begin
    grant_fire = (state_q == IDLE) && arb_any;
    req_ready  = (state_q == IDLE) ? arb_grant : '0;
    busy       = (state_q != IDLE);
  end

  // Command word for the state being entered. Addresses come straight from
  // the granted requester since the address state always follows the grant.
  always_comb begin
    ram_din_d = '0;
    case (state_d)
      WR_ADDR: ram_din_d = {CMD_WR_ADDR, addr_arr[arb_idx]};
      WR_DATA: ram_din_d = {CMD_WR_DATA, wdata_q};
      RD_ADDR: ram_din_d = {CMD_RD_ADDR, addr_arr[arb_idx]};
      RD_CMD:  ram_din_d = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
      default: ram_din_d = '0;
    endcase
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == PTR_W'(i));
    end
  end

  // Registered datapath: transaction capture, RAM command, timeout counter
  // and the response pulse. ram_din drops to zero with the strobe because
  // the RAM decodes din[9:8] even when rx_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= '0;
      wdata_q      <= '0;
      tmo_cnt_q    <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      ram_rx_valid <= issues_cmd(state_d);
      ram_din      <= ram_din_d;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;

      if (grant_fire) begin
        owner_q <= arb_idx;
        wdata_q <= wdata_arr[arb_idx];
      end

      case (state_q)
        WR_DATA: begin
          rsp_valid <= owner_oh;
        end
        RD_CMD: begin
          tmo_cnt_q <= '0;
        end
        RD_WAIT: begin
          if (ram_tx_valid) begin
            rsp_valid <= owner_oh;
            rsp_rdata <= ram_dout;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (rd_timeout_hit) begin
              rsp_valid <= owner_oh;
              rsp_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port RAM command interface between NUM_REQ requesters.
- Each requester issues whole write or read transactions. The block serialises them into the RAM's 10-bit command words:
  - write: 00+addr, then 01+data
  - read: 10+addr, then 11+dummy
- Collects read data from the RAM on tx_valid and returns it to the owning requester.
- Sits between the SPI/host-side masters and the RAM at the top level, replacing direct rx_valid/din wiring.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_SIZE, 8, RAM address and data width; command word is ADDR_SIZE+2 bits.
- RD_TIMEOUT, 4, cycles to wait in RD_WAIT for ram_tx_valid before returning an error (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_ready  out  NUM_REQ  one-hot grant/accept; transaction captured when valid&ready.
- req_write  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE].
- req_wdata  in  NUM_REQ*ADDR_SIZE  packed write data, same packing.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  ADDR_SIZE  read data, valid with rsp_valid; 0 for writes.
- rsp_err  out  1  read timeout flag, valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- ram_din  out  ADDR_SIZE+2  command word to RAM din.
- ram_rx_valid  out  1  command strobe to RAM.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read-data valid.

Behaviour:
- Reset values:
  - state IDLE.
  - req_ready, rsp_valid, rsp_err, busy, ram_rx_valid all 0.
  - rsp_rdata 0, ram_din 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: the in-flight transaction is dropped, no response is given, and there is no partial RAM write beyond commands already issued.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT.
- IDLE:
  - req_ready is combinational: one-hot for the round-robin winner among req_valid, searched from pointer+1 upward with wrap.
  - On grant, latch owner index, op, addr and wdata, and update pointer to the owner.
  - Next state is WR_ADDR (write) or RD_ADDR (read).
  - No grant if no req_valid.
- req_ready is 0 in every state except IDLE.
- Command issue: in WR_ADDR, WR_DATA, RD_ADDR and RD_CMD, ram_rx_valid=1 and ram_din is registered and valid that cycle.
  - WR_ADDR = {2'b00, addr}
  - WR_DATA = {2'b01, wdata}
  - RD_ADDR = {2'b10, addr}
  - RD_CMD = {2'b11, 0}
  - Each state lasts exactly one cycle.
- Whenever ram_rx_valid=0, ram_din is forced to all-zero, because the RAM derives tx_valid from din[9:8] regardless of rx_valid.
- Write timing (grant at cycle T):
  - WR_ADDR at T+1, WR_DATA at T+2.
  - At T+3: rsp_valid[owner]=1, rsp_rdata=0, rsp_err=0, state IDLE. A new grant may occur in that same cycle.
- Read timing (grant at cycle T):
  - RD_ADDR at T+1, RD_CMD at T+2, RD_WAIT from T+3.
  - In RD_WAIT, if ram_tx_valid=1: capture ram_dout and go to IDLE. rsp_valid[owner] and rsp_rdata are registered, appearing the next cycle (nominal T+4).
  - Timeout counter starts at 0 on entry and increments each RD_WAIT cycle without tx_valid. On reaching RD_TIMEOUT, go to IDLE with rsp_valid, rsp_err=1 and rsp_rdata=0.
- ram_tx_valid outside RD_WAIT is ignored.
- rsp_valid is a single-cycle pulse, one-hot, and never asserted for more than one requester.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
- Requesters may change req_* freely while not granted. Fields are sampled only on the grant cycle.

Decomposition:
- Package ram_arb_pkg:
  - state_e enum.
  - Command opcode constants: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Default ADDR_SIZE.
- Sub-module rr_arbiter (NUM_REQ):
  - Combinational one-hot winner from a request vector and pointer.
  - Registered pointer update on an advance strobe.
  - Reused elsewhere in the codebase.

Test Plan:
- Single write: req0 write addr 0x12 data 0xA5 -> ram_din 0x012 at T+1, then 0x1A5 at T+2. rsp_valid[0] at T+3. A subsequent read of 0x12 returns rsp_rdata 0xA5.
- Read of reset-preloaded RAM: req1 read addr 0x37 -> ram_din 0x237 then 0x300. rsp_valid[1] with rsp_rdata 0x37 and rsp_err=0 at T+4.
- Contention: req0 and req1 both hold valid with reads of 0x01/0x02 -> grants alternate 0,1,0,1. Each response goes to the correct requester with data 0x01/0x02.
- Timeout: RAM model with tx_valid forced 0, RD_TIMEOUT=4 -> rsp_valid with rsp_err=1 and rsp_rdata=0 exactly 4 cycles after RD_WAIT entry.
- Idle hygiene: no requests for 20 cycles -> ram_rx_valid=0, ram_din=0, and no rsp_valid.
- Reset mid-read: assert rst during RD_CMD -> all outputs 0 asynchronously and no rsp_valid after release. The next grant goes to requester 0.
